// File: rtl/mskaes_ks_pkg.sv
// Shared constants for the masked AES key-schedule sequencer:
// state encoding, per-mode Nk and last-word index, and mode decode helpers.
package mskaes_ks_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [3:0] NK_128 = 4'd4;
  localparam logic [3:0] NK_192 = 4'd6;
  localparam logic [3:0] NK_256 = 4'd8;

  localparam logic [5:0] LAST_128 = 6'd43;
  localparam logic [5:0] LAST_192 = 6'd51;
  localparam logic [5:0] LAST_256 = 6'd59;

  // 4*Nr+3 is 3 mod Nk for every key size, so a backward pass starts here
  localparam logic [2:0] INV_PHASE_START = 3'd3;

  function automatic logic [3:0] nk_of(input logic m192, input logic m256);
    logic [3:0] nk;
    if (m256) begin
      nk = NK_256;
    end else if (m192) begin
      nk = NK_192;
    end else begin
      nk = NK_128;
    end
    return nk;
  endfunction

  function automatic logic [5:0] last_of(input logic m192, input logic m256);
    logic [5:0] last;
    if (m256) begin
      last = LAST_256;
    end else if (m192) begin
      last = LAST_192;
    end else begin
      last = LAST_128;
    end
    return last;
  endfunction

endpackage

// File: rtl/mskaes_ks_ctrl_if.sv
// Handshake, configuration and rcon-generator control bundle of the
// key-schedule sequencer; the sequencer is the slave side.
interface mskaes_ks_ctrl_if;
  logic       start_valid;
  logic       start_ready;
  logic       mode_192;
  logic       mode_256;
  logic       inverse;
  logic       step_en;
  logic       rcon_init;
  logic       rcon_update;
  logic       mask_rcon;
  logic       rcon_mode_192;
  logic       rcon_mode_256;
  logic       rcon_inverse;
  logic       word_valid;
  logic [5:0] word_idx;
  logic       rot_sub;
  logic       sub_only;
  logic       last_word;
  logic       done;

  modport master (
    output start_valid, mode_192, mode_256, inverse, step_en,
    input  start_ready, rcon_init, rcon_update, mask_rcon,
    input  rcon_mode_192, rcon_mode_256, rcon_inverse,
    input  word_valid, word_idx, rot_sub, sub_only, last_word, done
  );

  modport slave (
    input  start_valid, mode_192, mode_256, inverse, step_en,
    output start_ready, rcon_init, rcon_update, mask_rcon,
    output rcon_mode_192, rcon_mode_256, rcon_inverse,
    output word_valid, word_idx, rot_sub, sub_only, last_word, done
  );
endinterface

// File: rtl/mskaes_ks_phase_cnt.sv
// Up/down modulo-Nk phase counter tracking word_idx mod Nk without a divider.
// Loads 0 (forward) or 3 (inverse) and flags phase 0 and phase 4.
module mskaes_ks_phase_cnt
  import mskaes_ks_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       step_i,
  input  logic       inverse_i,
  input  logic [3:0] nk_i,
  output logic       phase_zero_o,
  output logic       phase_four_o
);

  logic [2:0] phase_q;
  logic [2:0] phase_d;
  logic [3:0] nk_m1_full_s;
  logic [2:0] nk_m1_s;

  assign nk_m1_full_s = nk_i - 4'd1;
  assign nk_m1_s      = nk_m1_full_s[2:0];

  always_comb begin
    phase_d = phase_q;
    if (load_i) begin
      phase_d = inverse_i ? INV_PHASE_START : 3'd0;
    end else if (step_i) begin
      if (inverse_i) begin
        phase_d = (phase_q == 3'd0) ? nk_m1_s : (phase_q - 3'd1);
      end else begin
        phase_d = (phase_q == nk_m1_s) ? 3'd0 : (phase_q + 3'd1);
      end
    end else begin
      phase_d = phase_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 3'd0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase_zero_o = (phase_q == 3'd0);
  assign phase_four_o = (phase_q == 3'd4);

endmodule

// File: rtl/mskaes_ks_ctrl.sv
// Masked AES key-schedule sequencer: walks the expanded-key word index for
// AES-128/192/256 in either direction and drives the rcon generator controls.
module mskaes_ks_ctrl
  import mskaes_ks_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  mskaes_ks_ctrl_if.slave      bus
);

  logic [1:0] state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [5:0] end_idx_q;
  logic [3:0] nk_q;
  logic       inv_q, m192_q, m256_q;

  logic       hs_s, run_s, last_s, adv_s;
  logic       ph_zero_s, ph_four_s, ph_inv_s;

  assign hs_s   = bus.start_valid && (state_q == ST_IDLE);
  assign run_s  = (state_q == ST_RUN);
  assign last_s = run_s && (idx_q == end_idx_q);
  assign adv_s  = run_s && bus.step_en;

  // The counter must see the incoming direction on the load cycle
  assign ph_inv_s = hs_s ? bus.inverse : inv_q;

  mskaes_ks_phase_cnt u_phase (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (hs_s),
    .step_i       (adv_s),
    .inverse_i    (ph_inv_s),
    .nk_i         (nk_q),
    .phase_zero_o (ph_zero_s),
    .phase_four_o (ph_four_s)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = hs_s ? ST_LOAD : ST_IDLE;
      ST_LOAD: state_d = ST_RUN;
      ST_RUN:  state_d = (adv_s && last_s) ? ST_DONE : ST_RUN;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idx_d = idx_q;
    if (hs_s) begin
      idx_d = bus.inverse ? last_of(bus.mode_192, bus.mode_256)
                          : {2'b00, nk_of(bus.mode_192, bus.mode_256)};
    end else if (adv_s && !last_s) begin
      idx_d = inv_q ? (idx_q - 6'd1) : (idx_q + 6'd1);
    end else begin
      idx_d = idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= 6'd0;
      end_idx_q <= 6'd0;
      nk_q      <= NK_128;
      inv_q     <= 1'b0;
      m192_q    <= 1'b0;
      m256_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      // Config is frozen for the whole pass; 256 wins when both mode bits are set
      if (hs_s) begin
        nk_q      <= nk_of(bus.mode_192, bus.mode_256);
        end_idx_q <= bus.inverse ? {2'b00, nk_of(bus.mode_192, bus.mode_256)}
                                 : last_of(bus.mode_192, bus.mode_256);
        inv_q     <= bus.inverse;
        m192_q    <= bus.mode_192 && !bus.mode_256;
        m256_q    <= bus.mode_256;
      end else begin
        nk_q      <= nk_q;
        end_idx_q <= end_idx_q;
        inv_q     <= inv_q;
        m192_q    <= m192_q;
        m256_q    <= m256_q;
      end
    end
  end

  assign bus.start_ready   = (state_q == ST_IDLE);
  assign bus.rcon_init     = (state_q == ST_LOAD);
  assign bus.done          = (state_q == ST_DONE);
  assign bus.word_valid    = run_s;
  assign bus.word_idx      = idx_q;
  assign bus.rot_sub       = run_s && ph_zero_s;
  assign bus.sub_only      = run_s && (nk_q == NK_256) && ph_four_s;
  assign bus.last_word     = last_s;
  assign bus.mask_rcon     = run_s && ph_zero_s;
  assign bus.rcon_update   = adv_s && ph_zero_s;
  assign bus.rcon_mode_192 = m192_q;
  assign bus.rcon_mode_256 = m256_q;
  assign bus.rcon_inverse  = inv_q;

endmodule

// File: tb/tb_mskaes_ks_ctrl.sv
// Table-driven bench for mskaes_ks_ctrl with a paired rcon generator model,
// plus hand sequences for stalls, ignored restarts and mid-pass reset.
module tb_mskaes_ks_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  mskaes_ks_ctrl_if bus();

  mskaes_ks_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference rcon generator driven only by the sequencer's control outputs
  logic [7:0] gen_q = 8'h00;
  always @(posedge clk) begin
    if (bus.rcon_init) begin
      if (!bus.rcon_inverse)     gen_q <= 8'h01;
      else if (bus.rcon_mode_256) gen_q <= 8'h40;
      else if (bus.rcon_mode_192) gen_q <= 8'h80;
      else                        gen_q <= 8'h36;
    end else if (bus.rcon_update) begin
      if (bus.rcon_inverse)
        gen_q <= gen_q[0] ? ((gen_q >> 1) ^ 8'h8d) : (gen_q >> 1);
      else
        gen_q <= gen_q[7] ? ((gen_q << 1) ^ 8'h1b) : (gen_q << 1);
    end
  end

  typedef struct {
    logic       m192;
    logic       m256;
    logic       inv;
    int         nk;
    int         first;
    int         last;
    int         rots;
    int         subs;
    int         cycles;
    logic [7:0] rc_first;
    logic [7:0] rc_last;
    logic       rm192;
    logic       rm256;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_pass(input vec_t v, input bit stall, input bit poke);
    int exp_idx, cyc, rots, subs, upd, overlap, guard;
    logic [7:0] rc_first, rc_last;
    bit got_rc, fin, step, exp_rot, exp_sub;
    cyc = 0; rots = 0; subs = 0; upd = 0; overlap = 0; guard = 0;
    got_rc = 0; fin = 0; rc_first = 8'h00; rc_last = 8'h00;
    @(negedge clk);
    bus.mode_192 = v.m192; bus.mode_256 = v.m256; bus.inverse = v.inv;
    bus.start_valid = 1'b1; bus.step_en = 1'b0;
    chk("start_ready_idle", bus.start_ready, 1);
    @(negedge clk);
    bus.start_valid = poke;
    if (poke) begin
      bus.mode_192 = ~v.m192; bus.mode_256 = ~v.m256; bus.inverse = ~v.inv;
    end
    chk("load_rcon_init", bus.rcon_init, 1);
    chk("load_word_valid", bus.word_valid, 0);
    chk("load_start_ready", bus.start_ready, 0);
    chk("cfg_rcon_inverse", bus.rcon_inverse, v.inv);
    chk("cfg_rcon_mode_192", bus.rcon_mode_192, v.rm192);
    chk("cfg_rcon_mode_256", bus.rcon_mode_256, v.rm256);
    exp_idx = v.first;
    while (!fin && guard < 400) begin
      @(negedge clk);
      guard++;
      cyc++;
      exp_rot = ((exp_idx % v.nk) == 0);
      exp_sub = (v.nk == 8) && ((exp_idx % 8) == 4);
      chk("word_valid", bus.word_valid, 1);
      chk("word_idx", bus.word_idx, exp_idx);
      chk("rot_sub", bus.rot_sub, exp_rot);
      chk("sub_only", bus.sub_only, exp_sub);
      chk("mask_rcon", bus.mask_rcon, exp_rot);
      chk("last_word", bus.last_word, exp_idx == v.last);
      chk("run_start_ready", bus.start_ready, 0);
      chk("run_done", bus.done, 0);
      chk("run_rcon_inverse", bus.rcon_inverse, v.inv);
      if (bus.rot_sub && bus.sub_only) overlap++;
      if (bus.mask_rcon) begin
        if (!got_rc) rc_first = gen_q;
        got_rc = 1;
        rc_last = gen_q;
      end
      step = stall ? bit'($urandom_range(0, 1)) : 1'b1;
      bus.step_en = step;
      #1;
      chk("rcon_update", bus.rcon_update, step && exp_rot);
      if (step) begin
        if (bus.rcon_update) upd++;
        if (bus.rot_sub) rots++;
        if (bus.sub_only) subs++;
        if (exp_idx == v.last) begin
          fin = 1;
          bus.start_valid = 1'b0;
        end else begin
          exp_idx += v.inv ? -1 : 1;
        end
      end
    end
    if (!fin) begin
      n_checks++; n_fail++;
      $display("FAIL pass_timeout: last word not consumed within %0d cycles", guard);
    end
    @(negedge clk);
    bus.step_en = 1'b0;
    #1;
    chk("done_pulse", bus.done, 1);
    chk("done_word_valid", bus.word_valid, 0);
    chk("done_start_ready", bus.start_ready, 0);
    chk("done_rcon_update", bus.rcon_update, 0);
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);
    chk("ready_after_done", bus.start_ready, 1);
    chk("rot_count", rots, v.rots);
    chk("sub_count", subs, v.subs);
    chk("update_count", upd, v.rots);
    chk("rot_sub_overlap", overlap, 0);
    chk("rcon_first", rc_first, v.rc_first);
    chk("rcon_last", rc_last, v.rc_last);
    if (!stall) chk("run_cycles", cyc, v.cycles);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    vecs[0] = '{1'b0, 1'b0, 1'b0, 4, 4, 43, 10, 0, 40, 8'h01, 8'h36, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 6, 6, 51,  8, 0, 46, 8'h01, 8'h80, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 8, 8, 59,  7, 6, 52, 8'h01, 8'h40, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 4, 43, 4, 10, 0, 40, 8'h36, 8'h01, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 6, 51, 6,  8, 0, 46, 8'h80, 8'h01, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 8, 59, 8,  7, 6, 52, 8'h40, 8'h01, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 8, 8, 59,  7, 6, 52, 8'h01, 8'h40, 1'b0, 1'b1};

    rst_n = 1'b0;
    bus.start_valid = 1'b0; bus.mode_192 = 1'b0; bus.mode_256 = 1'b0;
    bus.inverse = 1'b0; bus.step_en = 1'b0;
    #12;
    chk("rst_start_ready", bus.start_ready, 1);
    chk("rst_word_idx", bus.word_idx, 0);
    chk("rst_word_valid", bus.word_valid, 0);
    chk("rst_rcon_init", bus.rcon_init, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rcon_cfg", {bus.rcon_mode_192, bus.rcon_mode_256, bus.rcon_inverse}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) do_pass(vecs[i], 1'b0, 1'b0);

    // Random stalls on AES-128 forward
    do_pass(vecs[0], 1'b1, 1'b0);
    // start_valid held with a different config during an AES-192 inverse pass
    do_pass(vecs[4], 1'b0, 1'b1);

    // Asynchronous reset in the middle of an AES-128 pass
    @(negedge clk);
    bus.mode_192 = 1'b0; bus.mode_256 = 1'b0; bus.inverse = 1'b0;
    bus.start_valid = 1'b1;
    @(negedge clk);
    bus.start_valid = 1'b0;
    bus.step_en = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(bus.word_valid && bus.word_idx == 6'd20) && guard < 100);
    chk("mid_reach_idx20", bus.word_idx, 20);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_word_valid", bus.word_valid, 0);
    chk("mid_rst_word_idx", bus.word_idx, 0);
    chk("mid_rst_start_ready", bus.start_ready, 1);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_flags", {bus.rot_sub, bus.sub_only, bus.last_word, bus.mask_rcon, bus.rcon_update}, 0);
    chk("mid_rst_rcon_cfg", {bus.rcon_mode_192, bus.rcon_mode_256, bus.rcon_inverse}, 0);
    bus.step_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid_rst_no_done", bus.done, 0);
      chk("mid_rst_idle", bus.start_ready, 1);
    end
    do_pass(vecs[0], 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
